// File: rtl/javk_bus_arb_if.sv
// javk_bus_arb_if: request/bus bundle between the JAVK bus masters and the arbiter.
//   req, lock      per-requester request level and bus lock
//   req_addr       flattened 16b addresses, requester i at [16i+15:16i]
//   req_rw         per-requester cycle type (1 = write)
//   req_wdata      flattened 8b write data, requester i at [8i+7:8i]
//   bus_din        databus input sample
//   gnt            one-hot grant
//   addrbus, rw    external address bus and write strobe
//   bus_dout       databus drive value (valid when rw=1)
//   rdata, rvalid  captured read data and its one-cycle qualifier
//   timeout        one-cycle pulse on forced release
// Modports: slave = arbiter side, master = requester side.
interface javk_bus_arb_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    lock;
   logic [NREQ*16-1:0] req_addr;
   logic [NREQ-1:0]    req_rw;
   logic [NREQ*8-1:0]  req_wdata;
   logic [7:0]         bus_din;
   logic [NREQ-1:0]    gnt;
   logic [15:0]        addrbus;
   logic               rw;
   logic [7:0]         bus_dout;
   logic [7:0]         rdata;
   logic               rvalid;
   logic               timeout;

   modport slave (
      input  req, lock, req_addr, req_rw, req_wdata, bus_din,
      output gnt, addrbus, rw, bus_dout, rdata, rvalid, timeout
   );

   modport master (
      output req, lock, req_addr, req_rw, req_wdata, bus_din,
      input  gnt, addrbus, rw, bus_dout, rdata, rvalid, timeout
   );
endinterface

// File: rtl/javk_bus_arb.sv
// javk_bus_arb: round-robin arbiter and sequencer for the JAVK external memory bus.
//   Shares the bus between the CPU core (requester 0) and NREQ-1 secondary masters,
//   registers the owner's address/rw/write data onto the bus and inserts one
//   turnaround cycle between owners.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   javk_bus_arb_if.slave (requests, per-requester payloads, bus outputs)
// Optional build: define BUS_ARB_TIMEOUT_EN to evict an unlocked owner after
//   MAX_HOLD consecutive grant cycles (timeout pulses on eviction).
module javk_bus_arb #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic          clk,
   input  logic          rst,
   javk_bus_arb_if.slave bus
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 8;
   localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_e;

   state_e           state_q,   state_d;
   logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
   logic [IDX_W-1:0] owner_q,   owner_d;
   logic [NREQ-1:0]  gnt_q,     gnt_d;
   logic [AW-1:0]    addr_q,    addr_d;
   logic             rw_q,      rw_d;
   logic [DW-1:0]    dout_q,    dout_d;
   logic [DW-1:0]    rdata_q,   rdata_d;
   logic             rvalid_q,  rvalid_d;
   logic             acc_q,     acc_d;
   logic             timeout_q, timeout_d;

   logic [AW-1:0]    addr_arr_c  [NREQ];
   logic [DW-1:0]    wdata_arr_c [NREQ];
   logic [IDX_W-1:0] win_idx_c;
   logic             win_found_c;
   logic             release_c;
   logic             expire_c;

   // Unpack the flattened per-requester payloads.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr_c[g]  = bus.req_addr[AW*g +: AW];
      assign wdata_arr_c[g] = bus.req_wdata[DW*g +: DW];
   end

   // Round-robin search starting just after the last winner; rr_ptr itself ranks last.
   always_comb begin
      int unsigned      idx;
      logic [IDX_W-1:0] cand;
      win_idx_c   = '0;
      win_found_c = 1'b0;
      idx         = 0;
      cand        = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         cand = IDX_W'(idx);
         if (!win_found_c && bus.req[cand]) begin
            win_found_c = 1'b1;
            win_idx_c   = cand;
         end
      end
   end

   assign release_c = !bus.req[owner_q] && !bus.lock[owner_q];

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int unsigned HW = 8;

   logic [HW-1:0] hold_q, hold_d;

   // Counts unlocked grant cycles; cleared while idle so each tenure starts at zero.
   always_comb begin
      hold_d = hold_q;
      if (state_q == S_IDLE) begin
         hold_d = '0;
      end else if ((state_q == S_GRANT) && !bus.lock[owner_q]) begin
         hold_d = hold_q + HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   // Expiry fires on the edge where the count would reach MAX_HOLD.
   assign expire_c = (state_q == S_GRANT) && !bus.lock[owner_q] &&
                     (hold_q == HW'(MAX_HOLD - 1));
`else
   assign expire_c = 1'b0;
`endif

   // Next-state and bus sequencing.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      rw_d      = 1'b0;
      dout_d    = dout_q;
      acc_d     = 1'b0;
      timeout_d = 1'b0;
      // A read driven last cycle completes now, whatever the current state.
      rvalid_d  = acc_q && !rw_q;
      rdata_d   = (acc_q && !rw_q) ? bus.bus_din : rdata_q;

      unique case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (win_found_c) begin
               state_d  = S_GRANT;
               owner_d  = win_idx_c;
               rr_ptr_d = win_idx_c;
               gnt_d    = GNT_ONE << win_idx_c;
            end
         end
         S_GRANT: begin
            if (release_c || expire_c) begin
               // addrbus keeps its last value through the turnaround.
               state_d   = S_TURN;
               gnt_d     = '0;
               timeout_d = expire_c && !release_c;
            end else begin
               addr_d = addr_arr_c[owner_q];
               rw_d   = bus.req_rw[owner_q];
               dout_d = wdata_arr_c[owner_q];
               acc_d  = 1'b1;
            end
         end
         S_TURN: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         dout_q    <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         acc_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         dout_q    <= dout_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         acc_q     <= acc_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.addrbus  = addr_q;
   assign bus.rw       = rw_q;
   assign bus.bus_dout = dout_q;
   assign bus.rdata    = rdata_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_javk_bus_arb.sv
// tb_javk_bus_arb: directed steps followed by random traffic, every cycle compared
// against a transaction-level reference model of the arbiter.
module tb_javk_bus_arb;

   localparam int unsigned NREQ     = 4;
   localparam int unsigned MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   javk_bus_arb_if #(.NREQ(NREQ)) bif ();

   javk_bus_arb #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: owner index (-1 = nobody), turnaround flag, last winner.
   int          m_owner;
   bit          m_turn;
   int          m_ptr;
   int          m_hold;
   logic [15:0] m_addr;
   bit          m_rw;
   logic [7:0]  m_dout;
   logic [7:0]  m_rdata;
   bit          m_rvalid;
   bit          m_timeout;
   bit          m_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] exp_gnt();
      logic [NREQ-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // Advance the model by one clock using the inputs as they stand before the edge.
   task automatic model_step();
      bit was_read;
      bit evict;
      int o;
      was_read  = m_acc && !m_rw;
      m_acc     = 1'b0;
      m_rvalid  = 1'b0;
      m_timeout = 1'b0;
      if (rst) begin
         m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_hold = 0;
         m_addr = '0; m_rw = 1'b0; m_dout = '0; m_rdata = '0;
         return;
      end
      if (was_read) begin
         m_rdata  = bif.bus_din;
         m_rvalid = 1'b1;
      end
      m_rw = 1'b0;
      if (m_owner >= 0) begin
         o = m_owner;
         if (!bif.req[o] && !bif.lock[o]) begin
            m_owner = -1;
            m_turn  = 1'b1;
         end else begin
            evict = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            if (!bif.lock[o]) begin
               m_hold++;
               if (m_hold >= MAX_HOLD) evict = 1'b1;
            end
`endif
            if (evict) begin
               m_owner   = -1;
               m_turn    = 1'b1;
               m_timeout = 1'b1;
            end else begin
               m_addr = bif.req_addr[16*o +: 16];
               m_rw   = bif.req_rw[o];
               m_dout = bif.req_wdata[8*o +: 8];
               m_acc  = 1'b1;
            end
         end
      end else if (m_turn) begin
         m_turn = 1'b0;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (bif.req[c]) begin
               m_owner = c;
               m_ptr   = c;
               m_hold  = 0;
               break;
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".gnt"},     32'(bif.gnt),      32'(exp_gnt()));
      check({tag, ".addr"},    32'(bif.addrbus),  32'(m_addr));
      check({tag, ".rw"},      32'(bif.rw),       32'(m_rw));
      check({tag, ".dout"},    32'(bif.bus_dout), 32'(m_dout));
      check({tag, ".rdata"},   32'(bif.rdata),    32'(m_rdata));
      check({tag, ".rvalid"},  32'(bif.rvalid),   32'(m_rvalid));
      check({tag, ".timeout"}, 32'(bif.timeout),  32'(m_timeout));
      check({tag, ".onehot"},  32'($countones(bif.gnt) <= 1), 32'(1));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic set_master(input int i, input logic [15:0] a, input logic rwv, input logic [7:0] d);
      bif.req_addr[16*i +: 16] = a;
      bif.req_rw[i]            = rwv;
      bif.req_wdata[8*i +: 8]  = d;
   endtask

   initial begin
      int order [5];
      order = '{1, 2, 3, 0, 1};

      rst           = 1'b1;
      bif.req       = '1;
      bif.lock      = '0;
      bif.req_addr  = '0;
      bif.req_rw    = '0;
      bif.req_wdata = '0;
      bif.bus_din   = '0;

      // Reset with every requester asking.
      tick("rst0");
      tick("rst1");
      check("rst_gnt",  32'(bif.gnt), 32'(0));
      check("rst_addr", 32'(bif.addrbus), 32'(0));
      rst = 1'b0;
      tick("first");
      check("first_gnt", 32'(bif.gnt), 32'(4'b0010));
      bif.req = '0;
      tick("first_rel");
      tick("first_turn");

      // CPU write.
      set_master(0, 16'h1234, 1'b1, 8'hA5);
      bif.req = 4'b0001;
      tick("wr_gnt");
      check("wr_gnt_val", 32'(bif.gnt), 32'(4'b0001));
      tick("wr_bus");
      check("wr_addr", 32'(bif.addrbus), 32'(16'h1234));
      check("wr_rw",   32'(bif.rw), 32'(1));
      check("wr_dout", 32'(bif.bus_dout), 32'(8'hA5));
      bif.req = '0;
      tick("wr_rel");
      check("wr_rel_rw",   32'(bif.rw), 32'(0));
      check("wr_rel_addr", 32'(bif.addrbus), 32'(16'h1234));
      tick("wr_turn");

      // CPU read.
      set_master(0, 16'h0040, 1'b0, 8'h00);
      bif.bus_din = 8'h5A;
      bif.req     = 4'b0001;
      tick("rd_gnt");
      check("rd_gnt_val", 32'(bif.gnt), 32'(4'b0001));
      tick("rd_bus");
      bif.req = '0;
      tick("rd_rel");
      check("rd_rdata",  32'(bif.rdata), 32'(8'h5A));
      check("rd_rvalid", 32'(bif.rvalid), 32'(1));
      tick("rd_after");
      check("rd_rvalid_drop", 32'(bif.rvalid), 32'(0));

      // Round-robin rotation with all requesting.
      for (int i = 0; i < NREQ; i++) set_master(i, 16'(16'h1000 * i + 16'h11), 1'(i % 2), 8'(8'h30 + i));
      bif.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick("rr_gnt");
         check("rr_order", 32'(bif.gnt), 32'(1) << order[i]);
         tick("rr_acc");
         bif.req[order[i]] = 1'b0;
         tick("rr_rel");
         check("rr_turn_rw", 32'(bif.rw), 32'(0));
         bif.req[order[i]] = 1'b1;
         tick("rr_idle");
         check("rr_idle_gnt", 32'(bif.gnt), 32'(0));
      end
      bif.req = '0;
      tick("rr_drain");

      // Locked owner keeps the bus with req low.
      bif.req  = 4'b0100;
      bif.lock = 4'b0100;
      tick("lk_gnt");
      bif.req = '0;
      for (int i = 0; i < 40; i++) begin
         tick("lk_hold");
         check("lk_gnt_val", 32'(bif.gnt), 32'(4'b0100));
         check("lk_no_to",   32'(bif.timeout), 32'(0));
      end
      bif.lock = '0;
      tick("lk_rel");
      tick("lk_turn");

`ifdef BUS_ARB_TIMEOUT_EN
      // Unlocked owner 1 evicted after MAX_HOLD grant cycles.
      bif.req = 4'b0010;
      tick("to_gnt");
      check("to_gnt_val", 32'(bif.gnt), 32'(4'b0010));
      bif.req = 4'b0011;
      for (int i = 1; i <= int'(MAX_HOLD); i++) begin
         tick("to_hold");
         check("to_pulse", 32'(bif.timeout), (i == int'(MAX_HOLD)) ? 32'(1) : 32'(0));
      end
      tick("to_turn");
      tick("to_next");
      check("to_next_gnt", 32'(bif.gnt), 32'(4'b0001));
      bif.req = '0;
      tick("to_rel");
      tick("to_idle");
`endif

      // Reset in the middle of a write tenure.
      bif.req_rw = '1;
      bif.req    = 4'b1111;
      tick("mr_gnt");
      tick("mr_acc");
      check("mr_rw_before", 32'(bif.rw), 32'(1));
      rst = 1'b1;
      tick("mr_rst");
      check("mr_gnt", 32'(bif.gnt), 32'(0));
      check("mr_rw",  32'(bif.rw), 32'(0));
      rst = 1'b0;
      tick("mr_regnt");
      check("mr_regnt_val", 32'(bif.gnt), 32'(4'b0010));

      // Random traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) bif.req = NREQ'($urandom);
         bif.lock = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
         for (int i = 0; i < NREQ; i++) set_master(i, 16'($urandom), 1'($urandom), 8'($urandom));
         bif.bus_din = 8'($urandom);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
